// File: rtl/fetch_unit.sv
// fetch_unit: single-entry instruction fetch stage.
// Requests instruction words from memory, holds one instruction for the
// decode controller, and redirects the fetch address on jumps, JR and
// taken branches (no delay slot). A redirect discards the held instruction
// and issues no request in that cycle.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  // Encodings of the jump field driven by the decode controller.
  // The reserved code 2'b11 behaves as sequential.
  localparam logic [1:0] JUMP_SEQ = 2'b00;
  localparam logic [1:0] JUMP_J   = 2'b01;
  localparam logic [1:0] JUMP_JR  = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;

  logic        consume;
  logic        redirect;
  logic        capture;
  logic        take_jr;
  logic        take_j;
  logic        take_branch;
  logic [31:0] j_target;
  logic [31:0] branch_target;
  logic [31:0] target;

  // Link value and memory address are straight views of the registers.
  assign pc_plus4  = instr_pc + 32'd4;
  assign imem_addr = fetch_pc;

  // Next-state logic: leave IDLE on the first cycle out of reset, then stay.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and redirect decode; control inputs only matter on consume.
  always_comb begin
    consume     = 1'b0;
    take_jr     = 1'b0;
    take_j      = 1'b0;
    take_branch = 1'b0;
    redirect    = 1'b0;
    imem_req    = 1'b0;
    capture     = 1'b0;

    consume     = instr_valid & ~stall;
    take_jr     = consume & (jump == JUMP_JR);
    take_j      = consume & (jump == JUMP_J);
    take_branch = consume & branch & branch_taken;
    redirect    = take_jr | take_j | take_branch;

    // Request only when the holding slot is free or being vacated this
    // cycle, and never in a redirect cycle: the old fetch_pc is stale then.
    imem_req    = (state == FETCH) & ~redirect & (~instr_valid | consume);
    capture     = imem_req & imem_ready;
  end

  // Redirect target with priority JR > J > branch; all sums wrap mod 2^32.
  always_comb begin
    j_target      = '0;
    branch_target = '0;
    target        = '0;

    j_target      = {pc_plus4[31:28], instr[25:0], 2'b00};
    branch_target = pc_plus4 + {branch_offset[29:0], 2'b00};

    if (jump == JUMP_JR) begin
      target = jr_target;
    end else if (jump == JUMP_J) begin
      target = j_target;
    end else if (jump == JUMP_SEQ || branch) begin
      target = branch_target;
    end else begin
      target = branch_target;
    end
  end

  // State, fetch address and holding register; reset overrides everything,
  // so a memory response arriving during reset is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here sees the pre-edge values of the others.
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect) begin
        fetch_pc    <= target;
        instr_valid <= 1'b0;
      end else if (capture) begin
        instr       <= imem_rdata;
        instr_pc    <= fetch_pc;
        instr_valid <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed reset/stall/throughput checks plus scoreboarded
// programs. A program is a list of per-instruction control decisions; the
// reference model walks it at the instruction level (pc sequence) and the
// monitor compares every consumed instruction against that sequence.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  jump;
  logic        branch;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  typedef struct {
    logic [1:0]  jump;
    logic        branch;
    logic        taken;
    logic [31:0] offset;
    logic [31:0] jrt;
  } dec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] next_pc;
    bit          redir;
  } exp_t;

  dec_t        prog[$];
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          sb_en = 0;
  bit          chk_redir = 0;
  logic [31:0] redir_pc;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .jump          (jump),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jr_target     (jr_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a bijective scramble of the address, with one fixed
  // J instruction planted at 0x10000000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0000) return 32'h0800_0010;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  function automatic bit is_redirect(input dec_t d);
    return (d.jump == 2'b10) || (d.jump == 2'b01) || (d.branch && d.taken);
  endfunction

  // Instruction-level successor of pc under decision d.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input dec_t d);
    logic [31:0] word;
    word = mem_word(pc);
    if (d.jump == 2'b10) return d.jrt;
    if (d.jump == 2'b01) return ((pc + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (d.branch && d.taken) return pc + 32'd4 + (d.offset << 2);
    return pc + 32'd4;
  endfunction

  function automatic dec_t mk(input logic [1:0] j, input logic b, input logic t,
                              input logic [31:0] off, input logic [31:0] jt);
    dec_t d;
    d.jump = j; d.branch = b; d.taken = t; d.offset = off; d.jrt = jt;
    return d;
  endfunction

  // Non-redirecting decision with random noise on the ignored fields.
  function automatic dec_t mk_seq();
    logic [1:0] j;
    logic       b;
    j = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    b = 1'($urandom_range(0, 1));
    return mk(j, b, ~b, $urandom(), $urandom());
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the expected instruction on every consume.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (sb_en && !rst) begin
      if (chk_redir) begin
        check("redirect_addr", imem_addr, redir_pc);
        check("redirect_invalid", {31'd0, instr_valid}, 32'd0);
        chk_redir = 0;
      end
      if (instr_valid && stall) check("stall_no_req", {31'd0, imem_req}, 32'd0);
      if (instr_valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_consume", instr_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.word);
          check("pc_plus4", pc_plus4, e.pc + 32'd4);
          if (e.redir) begin
            check("redirect_no_req", {31'd0, imem_req}, 32'd0);
            chk_redir = 1;
            redir_pc  = e.next_pc;
          end
        end
      end
    end
  end

  // Resets the DUT, walks prog through the model, then drives random
  // stall/ready until every decision has been consumed.
  task automatic run_program(input int stall_pct, input int ready_pct,
                             input int budget, output int cycles);
    int          k;
    exp_t        e;
    logic [31:0] pc;
    dec_t        d;
    k = 0; cycles = 0; pc = 32'd0;
    exp_q.delete();
    foreach (prog[i]) begin
      e.pc      = pc;
      e.word    = mem_word(pc);
      e.next_pc = model_next(pc, prog[i]);
      e.redir   = is_redirect(prog[i]);
      exp_q.push_back(e);
      pc = e.next_pc;
    end
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_redir = 0;
    rst = 1'b0;
    sb_en = 1;
    while (k < prog.size() && cycles < budget) begin
      d = prog[k];
      jump = d.jump; branch = d.branch; branch_taken = d.taken;
      branch_offset = d.offset; jr_target = d.jrt;
      stall      = ($urandom_range(0, 99) < stall_pct);
      imem_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (instr_valid && !stall) k++;
      cycles++;
      @(negedge clk);
    end
    stall = 1'b1;
    #3;
    sb_en = 0;
    check("program_done", k, prog.size());
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  found;
    int  tmp;
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; jump = 2'b00;
    branch = 1'b0; branch_taken = 1'b0; branch_offset = '0; jr_target = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #2;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Streaming start-up: addresses 0,4,8,... and valid from the 3rd cycle.
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b1;
    #2;
    check("s0_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #2;
    check("s1_req", {31'd0, imem_req}, 32'd1);
    check("s1_addr", imem_addr, 32'd0);
    check("s1_valid", {31'd0, instr_valid}, 32'd0);
    for (int s = 2; s <= 6; s++) begin
      @(negedge clk); #2;
      check("stream_valid", {31'd0, instr_valid}, 32'd1);
      check("stream_pc", instr_pc, 32'(4 * (s - 2)));
      check("stream_addr", imem_addr, 32'(4 * (s - 1)));
      check("stream_instr", instr, mem_word(32'(4 * (s - 2))));
    end

    // Three stalled cycles hold the instruction and suppress requests.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      stall = 1'b1;
      #2;
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_pc", instr_pc, 32'h14);
      check("stall_instr", instr, mem_word(32'h14));
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    #2;
    check("resume_pc", instr_pc, 32'h14);
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h18);
    @(negedge clk); #2;
    check("resume_next_pc", instr_pc, 32'h18);

    // Reset during a pending request at address 0x8.
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (imem_addr == 32'h8) found = 1;
    end
    check("reach_addr8", {31'd0, found}, 32'd1);
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    check("pre_rst_addr", imem_addr, 32'h8);
    @(negedge clk);
    imem_ready = 1'b1;
    #2;
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_instr_pc", instr_pc, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_resp_ignored", instr, 32'd0);
    check("restart_idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #2;
    check("restart_addr", imem_addr, 32'd0);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk); #2;
    check("restart_instr_pc", instr_pc, 32'd0);
    check("restart_instr", instr, mem_word(32'd0));

    // Program A: branch back from 0x40, J, JR-over-branch, reserved jump,
    // untaken branch and address wrap.
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(mk_seq());
    prog.push_back(mk(2'b00, 1'b1, 1'b1, 32'hFFFF_FFFE, $urandom()));
    prog.push_back(mk(2'b10, 1'b0, 1'b0, $urandom(), 32'h1000_0000));
    prog.push_back(mk(2'b01, 1'b0, 1'b0, $urandom(), $urandom()));
    prog.push_back(mk(2'b10, 1'b1, 1'b1, $urandom(), 32'h0000_0200));
    prog.push_back(mk(2'b11, 1'b0, 1'b0, $urandom(), $urandom()));
    prog.push_back(mk(2'b00, 1'b1, 1'b0, $urandom(), $urandom()));
    prog.push_back(mk(2'b10, 1'b0, 1'b0, $urandom(), 32'hFFFF_FFF8));
    for (int i = 0; i < 6; i++) prog.push_back(mk_seq());
    run_program(25, 70, 2000, cyc);

    // Program B: random mix of all decision kinds.
    prog.delete();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        5, 6: begin
          tmp = int'($urandom_range(0, 127)) - 64;
          prog.push_back(mk(2'b00, 1'b1, 1'b1, 32'(tmp), $urandom()));
        end
        7: prog.push_back(mk(2'b01, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             $urandom(), $urandom()));
        8: prog.push_back(mk(2'b10, 1'b0, 1'b0, $urandom(), $urandom() & 32'hFFFF_FFFC));
        9: prog.push_back(mk(2'b10, 1'b1, 1'b1, $urandom(), $urandom() & 32'hFFFF_FFFC));
        default: prog.push_back(mk_seq());
      endcase
    end
    run_program(30, 60, 20000, cyc);

    // Program C: no redirects, no stalls, memory always ready: two cycles of
    // start-up latency, then one instruction per cycle.
    prog.delete();
    for (int i = 0; i < 50; i++) prog.push_back(mk_seq());
    run_program(0, 100, 1000, cyc);
    check("throughput_cycles", cyc, 32'd52);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
